jk_excite_driver: RTL and testbench
===================================

JK_EXCITE_DRIVER -- requirements
Module: jk_excite_driver

Interface
REQ-001 Parameter: DEPTH, default 8; maximum pattern length in bits (DEPTH >= 2).
REQ-002 Parameter: IW, default 3; width of err_idx, equal to clog2(DEPTH).
REQ-003 The port list SHALL be exactly as follows (clock and reset first):
- CLK  input  1  sole clock; all state changes on posedge.
- rst_n  input  1  reset, synchronous and active-low, sampled on posedge CLK.
- start  input  1  request to run a pattern; accepted only when busy=0.
- pattern  input  DEPTH  target Q sequence; bit 0 is applied first; latched on accept.
- len  input  IW+1  number of pattern bits to apply, valid range 1..DEPTH; latched on accept.
- mode  input  1  0 = set/reset excitation, 1 = hold/toggle excitation; latched on accept.
- Q_fb  input  1  Q fed back from the external JK flip-flop driven by J/K.
- J  output  1  registered J drive to the external flop.
- K  output  1  registered K drive to the external flop.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle completion pulse.
- error  output  1  sticky mismatch or configuration-fault flag; cleared on the next accept.
- err_idx  output  IW  pattern index of the first mismatch.

Function
REQ-004 FSM states: IDLE, INIT, RUN, CHECK, DONE. All outputs are registered.
REQ-005 IDLE: J=K=0, busy=0. If start=1 with 1<=len<=DEPTH, latch pattern, len and mode, clear error and err_idx, and go to INIT.
REQ-006 IDLE, start=1 with len=0 or len>DEPTH: go to DONE, set error=1, err_idx=0, and do not drive the flop.
REQ-007 INIT: lasts one cycle; drives J=0, K=1 to force the external flop to Q=0; the expected previous Q (prev) is set to 0; idx=0.
REQ-008 RUN: lasts len cycles, idx=0..len-1. In each cycle J/K encode the transition prev -> pattern[idx]:
- mode 0, next=0: J=0, K=1.
- mode 0, next=1: J=1, K=0.
- mode 1, next=prev: J=0, K=0.
- mode 1, next!=prev: J=1, K=1.
REQ-009 RUN: after each cycle, prev <= pattern[idx]; idx increments; leaving idx=len-1 goes to CHECK.
REQ-010 Feedback check: Q_fb is compared on every RUN and CHECK cycle.
- RUN idx=0: expected Q_fb=0.
- RUN idx=k (k>=1): expected Q_fb=pattern[k-1].
- CHECK: expected Q_fb=pattern[len-1].
- CHECK drives J=K=0 and lasts one cycle, then goes to DONE.
REQ-011 On the first mismatch: set error=1; set err_idx to the index of the checked bit (0 for RUN idx=0 and idx=1, k-1 for RUN idx=k, len-1 for CHECK); J=K=0 from the next cycle; go directly to DONE.
REQ-012 DONE: done=1 and busy=0 for exactly one cycle; J=K=0; then return to IDLE. start asserted during DONE is ignored.
REQ-013 start while busy=1 SHALL be ignored; latched pattern, len and mode are unaffected.
REQ-014 Latency: with accept at edge 0, INIT occupies cycle 1, RUN occupies cycles 2..len+1, CHECK occupies cycle len+2, and done=1 in cycle len+3.
REQ-015 error and err_idx SHALL hold their values in IDLE until the next accepted start.

Reset
REQ-016 rst_n=0 at posedge SHALL force IDLE with J=0, K=0, busy=0, done=0, error=0, err_idx=0, idx=0, prev=0.
REQ-017 Reset has priority over every state, including mid-RUN; done is not pulsed for an aborted run.

Verification
REQ-018 Bench SHALL model the external flop as an ideal JK flip-flop (Q updates on posedge from J/K, reset 0) unless fault injection is stated, and SHALL cover these scenarios:
- S1: mode=1, pattern=8'hB2, len=8 -> RUN J/K = 00,11,11,00,11,00,11,11; done in cycle 11; error=0.
- S2: mode=0, pattern=8'hB2, len=8 -> RUN J/K = 01,10,01,01,10,10,01,10; done in cycle 11; error=0.
- S3: Q_fb stuck at 0, mode=0, pattern=8'h02, len=2 -> mismatch in CHECK; error=1, err_idx=1; done in cycle 5.
- S4: rst_n=0 during RUN idx=3 -> next cycle J=K=0, busy=0, done=0, error=0.
- S5: start with len=0 -> done=1 and error=1 in the next cycle, J/K stay 00; start pulses during busy are ignored.
- S6: back-to-back runs -> the second start, asserted in the cycle after done, is accepted, and error from a failing first run is cleared on that accept.

Source files
------------

// File: rtl/jk_excite_driver.sv
// Drives J/K of an external JK flip-flop so its Q walks through a latched bit
// pattern, checking the fed-back Q each cycle and flagging the first mismatch.
module jk_excite_driver #(
    parameter int DEPTH = 8,
    parameter int IW    = 3
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DEPTH-1:0] pattern,
    input  logic [IW:0]      len,
    input  logic             mode,
    input  logic             Q_fb,
    output logic             J,
    output logic             K,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [IW-1:0]    err_idx
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IW:0]   DEPTH_L = (IW+1)'(DEPTH);
    localparam logic [IW:0]   LEN_ONE = (IW+1)'(1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    logic [2:0]       state;
    logic [DEPTH-1:0] pat_q;
    logic [IW:0]      len_q;
    logic             mode_q;
    logic [IW-1:0]    idx;
    logic             prev;

    logic             len_ok;
    logic             accept;
    logic             last_bit;
    logic             q_miss;
    logic [IW-1:0]    idx_inc;
    logic [IW-1:0]    chk_idx;
    logic [1:0]       jk_next;

    // Encode the transition prev -> nxt as a J/K pair for the selected mode.
    function automatic logic [1:0] jk_enc(input logic m, input logic p, input logic nxt);
        if (m) begin
            return {p ^ nxt, p ^ nxt};
        end
        return {nxt, ~nxt};
    endfunction

    assign len_ok   = (len != '0) && (len <= DEPTH_L);
    assign accept   = (state == S_IDLE) && start && len_ok;
    assign last_bit = ({1'b0, idx} == (len_q - LEN_ONE));
    // prev always holds the Q the flop should show during the current cycle.
    assign q_miss   = (Q_fb != prev);
    assign idx_inc  = idx + IDX_ONE;
    assign chk_idx  = ((state == S_RUN) && (idx != '0)) ? (idx - IDX_ONE) : idx;
    assign jk_next  = jk_enc(mode_q, pat_q[idx], pat_q[idx_inc]);

    // Run configuration is plain data: captured on accept, never reset.
    always_ff @(posedge CLK) begin
        if (accept) begin
            pat_q  <= pattern;
            len_q  <= len;
            mode_q <= mode;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            J       <= 1'b0;
            K       <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            error   <= 1'b0;
            err_idx <= '0;
            idx     <= '0;
            prev    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    J    <= 1'b0;
                    K    <= 1'b0;
                    busy <= 1'b0;
                    if (start) begin
                        if (len_ok) begin
                            state   <= S_INIT;
                            busy    <= 1'b1;
                            error   <= 1'b0;
                            err_idx <= '0;
                            J       <= 1'b0;
                            K       <= 1'b1;
                            idx     <= '0;
                            prev    <= 1'b0;
                        end else begin
                            state   <= S_DONE;
                            done    <= 1'b1;
                            error   <= 1'b1;
                            err_idx <= '0;
                        end
                    end
                end
                S_INIT: begin
                    state  <= S_RUN;
                    idx    <= '0;
                    prev   <= 1'b0;
                    {J, K} <= jk_enc(mode_q, 1'b0, pat_q[0]);
                end
                S_RUN: begin
                    if (q_miss) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        error   <= 1'b1;
                        err_idx <= chk_idx;
                        J       <= 1'b0;
                        K       <= 1'b0;
                    end else if (last_bit) begin
                        state <= S_CHECK;
                        prev  <= pat_q[idx];
                        J     <= 1'b0;
                        K     <= 1'b0;
                    end else begin
                        idx    <= idx_inc;
                        prev   <= pat_q[idx];
                        {J, K} <= jk_next;
                    end
                end
                S_CHECK: begin
                    state <= S_DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    J     <= 1'b0;
                    K     <= 1'b0;
                    if (q_miss) begin
                        error   <= 1'b1;
                        err_idx <= chk_idx;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    J     <= 1'b0;
                    K     <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    J     <= 1'b0;
                    K     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excite_driver.sv
// Scoreboard bench for jk_excite_driver with an ideal JK flop closing the loop.
module tb_jk_excite_driver;

    localparam int DEPTH = 8;
    localparam int IW    = 3;

    logic             CLK = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [DEPTH-1:0] pattern = '0;
    logic [IW:0]      len = '0;
    logic             mode = 1'b0;
    logic             Q_fb;
    logic             J, K, busy, done, error;
    logic [IW-1:0]    err_idx;

    logic q_mdl;
    logic stuck_en  = 1'b0;
    logic stuck_val = 1'b0;

    int checks = 0;
    int passed = 0;

    // Expected per-cycle {J, K, busy, done, error, err_idx}
    logic [7:0] exp_q[$];

    logic [1:0] s1_jk [8] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
    logic [1:0] s2_jk [8] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b10};

    always #5 CLK = ~CLK;

    always_ff @(posedge CLK) begin
        if (!rst_n) q_mdl <= 1'b0;
        else begin
            case ({J, K})
                2'b01:   q_mdl <= 1'b0;
                2'b10:   q_mdl <= 1'b1;
                2'b11:   q_mdl <= ~q_mdl;
                default: q_mdl <= q_mdl;
            endcase
        end
    end

    assign Q_fb = stuck_en ? stuck_val : q_mdl;

    jk_excite_driver #(.DEPTH(DEPTH), .IW(IW)) dut (
        .CLK(CLK), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len),
        .mode(mode), .Q_fb(Q_fb), .J(J), .K(K), .busy(busy), .done(done),
        .error(error), .err_idx(err_idx)
    );

    function automatic void push(input logic [1:0] jk, input logic b, input logic d,
                                 input logic e, input logic [2:0] ei);
        exp_q.push_back({jk, b, d, e, ei});
    endfunction

    // Reference: INIT, len RUN cycles, CHECK, DONE, one idle cycle.
    function automatic void push_good(input logic [7:0] pat, input int l, input logic m);
        logic p;
        logic n;
        logic [1:0] jk;
        p = 1'b0;
        push(2'b01, 1, 0, 0, 3'd0);
        for (int i = 0; i < l; i++) begin
            n = pat[i];
            if (m) jk = (n != p) ? 2'b11 : 2'b00;
            else   jk = n ? 2'b10 : 2'b01;
            push(jk, 1, 0, 0, 3'd0);
            p = n;
        end
        push(2'b00, 1, 0, 0, 3'd0);
        push(2'b00, 0, 1, 0, 3'd0);
        push(2'b00, 0, 0, 0, 3'd0);
    endfunction

    task automatic start_run(input logic [7:0] pat, input logic [3:0] l, input logic m);
        start   = 1'b1;
        pattern = pat;
        len     = l;
        mode    = m;
        @(posedge CLK);
        #1 start = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] got;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        got = {J, K, busy, done, error, err_idx};
        checks++;
        if (got !== 8'h00) $display("FAIL reset_hold got=%b exp=%b", got, 8'h00);
        else passed++;
        rst_n = 1'b1;
        @(negedge CLK);
        got = {J, K, busy, done, error, err_idx};
        checks++;
        if (got !== 8'h00) $display("FAIL reset_idle got=%b exp=%b", got, 8'h00);
        else passed++;
    endtask

    task automatic test_s1_s2();
        logic [7:0] got, e;
        int cyc;
        for (int s = 0; s < 2; s++) begin
            start_run(8'hB2, 4'd8, (s == 0));
            push(2'b01, 1, 0, 0, 3'd0);
            for (int i = 0; i < 8; i++) push((s == 0) ? s1_jk[i] : s2_jk[i], 1, 0, 0, 3'd0);
            push(2'b00, 1, 0, 0, 3'd0);
            push(2'b00, 0, 1, 0, 3'd0);
            push(2'b00, 0, 0, 0, 3'd0);
            cyc = 0;
            while (exp_q.size() != 0) begin
                @(negedge CLK);
                cyc++;
                e = exp_q.pop_front();
                got = {J, K, busy, done, error, err_idx};
                checks++;
                if (got !== e) $display("FAIL s%0d cycle %0d got=%b exp=%b", s + 1, cyc, got, e);
                else passed++;
            end
        end
    endtask

    task automatic test_mismatch();
        logic [7:0] got, e;
        int cyc;
        // Stuck-at-0, caught in CHECK
        stuck_en = 1'b1; stuck_val = 1'b0;
        start_run(8'h02, 4'd2, 1'b0);
        push(2'b01, 1, 0, 0, 3'd0);
        push(2'b01, 1, 0, 0, 3'd0);
        push(2'b10, 1, 0, 0, 3'd0);
        push(2'b00, 1, 0, 0, 3'd0);
        push(2'b00, 0, 1, 1, 3'd1);
        push(2'b00, 0, 0, 1, 3'd1);
        // Stuck-at-1, caught at RUN idx=0
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK); cyc++;
            e = exp_q.pop_front();
            got = {J, K, busy, done, error, err_idx};
            checks++;
            if (got !== e) $display("FAIL s3_check cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
        end
        stuck_val = 1'b1;
        start_run(8'h00, 4'd3, 1'b0);
        push(2'b01, 1, 0, 0, 3'd0);
        push(2'b01, 1, 0, 0, 3'd0);
        push(2'b00, 0, 1, 1, 3'd0);
        push(2'b00, 0, 0, 1, 3'd0);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK); cyc++;
            e = exp_q.pop_front();
            got = {J, K, busy, done, error, err_idx};
            checks++;
            if (got !== e) $display("FAIL s3_idx0 cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
        end
        // Stuck-at-0, caught at RUN idx=4 (checks pattern bit 3)
        stuck_val = 1'b0;
        start_run(8'h08, 4'd6, 1'b1);
        push(2'b01, 1, 0, 0, 3'd0);
        push(2'b00, 1, 0, 0, 3'd0);
        push(2'b00, 1, 0, 0, 3'd0);
        push(2'b00, 1, 0, 0, 3'd0);
        push(2'b11, 1, 0, 0, 3'd0);
        push(2'b11, 1, 0, 0, 3'd0);
        push(2'b00, 0, 1, 1, 3'd3);
        push(2'b00, 0, 0, 1, 3'd3);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK); cyc++;
            e = exp_q.pop_front();
            got = {J, K, busy, done, error, err_idx};
            checks++;
            if (got !== e) $display("FAIL s3_mid cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
        end
        stuck_en = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] got, e;
        int cyc;
        start_run(8'hB2, 4'd8, 1'b1);
        push(2'b01, 1, 0, 0, 3'd0);
        for (int i = 0; i < 4; i++) push(s1_jk[i], 1, 0, 0, 3'd0);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK); cyc++;
            e = exp_q.pop_front();
            got = {J, K, busy, done, error, err_idx};
            checks++;
            if (got !== e) $display("FAIL s4_pre cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
        end
        rst_n = 1'b0;
        @(posedge CLK);
        #1 rst_n = 1'b1;
        push(2'b00, 0, 0, 0, 3'd0);
        push(2'b00, 0, 0, 0, 3'd0);
        push(2'b00, 0, 0, 0, 3'd0);
        while (exp_q.size() != 0) begin
            @(negedge CLK); cyc++;
            e = exp_q.pop_front();
            got = {J, K, busy, done, error, err_idx};
            checks++;
            if (got !== e) $display("FAIL s4_post cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
        end
    endtask

    task automatic test_config_and_ignore();
        logic [7:0] got, e;
        int cyc;
        for (int s = 0; s < 2; s++) begin
            start_run(8'hFF, (s == 0) ? 4'd0 : 4'd9, 1'b0);
            push(2'b00, 0, 1, 1, 3'd0);
            push(2'b00, 0, 0, 1, 3'd0);
            cyc = 0;
            while (exp_q.size() != 0) begin
                @(negedge CLK); cyc++;
                e = exp_q.pop_front();
                got = {J, K, busy, done, error, err_idx};
                checks++;
                if (got !== e) $display("FAIL s5_len%0d cycle %0d got=%b exp=%b", s, cyc, got, e);
                else passed++;
            end
        end
        // Starts while busy and during DONE must not disturb the run
        start_run(8'h05, 4'd4, 1'b0);
        push_good(8'h05, 4, 1'b0);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK); cyc++;
            e = exp_q.pop_front();
            got = {J, K, busy, done, error, err_idx};
            checks++;
            if (got !== e) $display("FAIL s5_ignore cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
            if (cyc == 3 || cyc == 7) begin
                start = 1'b1; pattern = 8'hFF; len = 4'd8; mode = 1'b1;
            end else if (cyc == 4 || cyc == 8) begin
                start = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got, e;
        int cyc;
        stuck_en = 1'b1; stuck_val = 1'b0;
        start_run(8'h02, 4'd2, 1'b0);
        push(2'b01, 1, 0, 0, 3'd0);
        push(2'b01, 1, 0, 0, 3'd0);
        push(2'b10, 1, 0, 0, 3'd0);
        push(2'b00, 1, 0, 0, 3'd0);
        push(2'b00, 0, 1, 1, 3'd1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK); cyc++;
            e = exp_q.pop_front();
            got = {J, K, busy, done, error, err_idx};
            checks++;
            if (got !== e) $display("FAIL s6_first cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
        end
        stuck_en = 1'b0;
        @(negedge CLK);
        got = {J, K, busy, done, error, err_idx};
        checks++;
        if (got !== 8'b00_0_0_1_001) $display("FAIL s6_gap got=%b exp=%b", got, 8'b00_0_0_1_001);
        else passed++;
        start_run(8'h6C, 4'd7, 1'b1);
        push_good(8'h6C, 7, 1'b1);
        cyc = 0;
        while (exp_q.size() != 0) begin
            @(negedge CLK); cyc++;
            e = exp_q.pop_front();
            got = {J, K, busy, done, error, err_idx};
            checks++;
            if (got !== e) $display("FAIL s6_second cycle %0d got=%b exp=%b", cyc, got, e);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [7:0] got, e, pat;
        logic [3:0] l;
        logic m;
        int cyc;
        for (int r = 0; r < 6; r++) begin
            pat = 8'($urandom);
            l   = (r == 0) ? 4'd1 : (r == 1) ? 4'd8 : 4'($urandom_range(1, 8));
            m   = 1'($urandom_range(0, 1));
            start_run(pat, l, m);
            push_good(pat, int'(l), m);
            cyc = 0;
            while (exp_q.size() != 0) begin
                @(negedge CLK); cyc++;
                e = exp_q.pop_front();
                got = {J, K, busy, done, error, err_idx};
                checks++;
                if (got !== e)
                    $display("FAIL rand pat=%h len=%0d mode=%0d cycle %0d got=%b exp=%b",
                             pat, l, m, cyc, got, e);
                else passed++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_s1_s2();
        test_mismatch();
        test_reset_mid_run();
        test_config_and_ignore();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
